// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, operand
// register addresses and the frame-decoding state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned ADDR_OP_A = 0;
  localparam int unsigned ADDR_OP_B = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FN,
    ALU_WAIT,
    TX_SEND
  } state_e;

endpackage

// File: rtl/tx_word_serializer.sv
// Emits a loaded word as DATA_WIDTH slices, least significant slice first,
// one per cycle while the downstream FIFO is not full.
module tx_word_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [CNT_W-1:0]      count,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_vld,
  output logic                  done_c
);

  logic [WORD_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]      left_q;
  logic                  emit_c;

  assign emit_c = (left_q != '0) && !fifo_full;
  assign done_c = emit_c && (left_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      left_q  <= '0;
      tx_data <= '0;
      tx_vld  <= 1'b0;
    end else begin
      tx_vld <= emit_c;
      if (load) begin
        shreg_q <= word;
        left_q  <= count;
      end else if (emit_c) begin
        tx_data <= shreg_q[DATA_WIDTH-1:0];
        shreg_q <= shreg_q >> DATA_WIDTH;
        left_q  <= left_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sys_ctrl_param.sv
// Command-frame controller: decodes RX frames into register file and ALU
// transactions and streams responses into the TX FIFO.
module sys_ctrl_param
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned FUN_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_VALID,
  input  logic                     FIFO_FULL,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     FRAME_ERR
);

  localparam int unsigned NB    = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(NB + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]   alu_fun_q, alu_fun_d;
  logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                   alu_en_q, alu_en_d, alu_go_q, alu_go_d;
  logic                   clk_en_q, clk_en_d, err_q, err_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   timed_c, expire_c, ld_c, done_c;
  logic [ALU_OUT_WIDTH-1:0] ld_word_c;
  logic [CNT_W-1:0]       ld_cnt_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_go_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      alu_go_q  <= alu_go_d;
      clk_en_q  <= clk_en_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    clk_en_d  = clk_en_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = alu_go_q;
    alu_go_d  = 1'b0;
    err_d     = 1'b0;
    ld_c      = 1'b0;
    ld_word_c = '0;
    ld_cnt_c  = '0;
    tmo_d     = '0;
    expire_c  = 1'b0;
    timed_c   = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN};

    // Inter-byte timeout; an arriving byte always clears the count
    if (timed_c && !RX_D_VLD && (TIMEOUT_CYC != 0)) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC) - TMO_W'(1)) expire_c = 1'b1;
      else tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_d = WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = OP_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ALU_FN;
          else                                            err_d   = 1'b1;
        end
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = ADDR_WIDTH'(RX_P_DATA);
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d  = ADDR_WIDTH'(RX_P_DATA);
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        err_d = RX_D_VLD;
        if (RdData_Valid) begin
          ld_c      = 1'b1;
          ld_word_c = ALU_OUT_WIDTH'(RdData);
          ld_cnt_c  = CNT_W'(1);
          state_d   = TX_SEND;
        end
      end
      OP_A: if (RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(ADDR_OP_A);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(ADDR_OP_B);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = ALU_FN;
      end
      ALU_FN: if (RX_D_VLD) begin
        alu_fun_d = FUN_WIDTH'(RX_P_DATA);
        clk_en_d  = 1'b1;
        alu_go_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: begin
        err_d = RX_D_VLD;
        if (OUT_VALID) begin
          clk_en_d  = 1'b0;
          ld_c      = 1'b1;
          ld_word_c = ALU_OUT;
          ld_cnt_c  = CNT_W'(NB);
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        err_d = RX_D_VLD;
        if (done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (expire_c) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  tx_word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (ALU_OUT_WIDTH),
    .CNT_W      (CNT_W)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (ld_c),
    .word      (ld_word_c),
    .count     (ld_cnt_c),
    .fifo_full (FIFO_FULL),
    .tx_data   (TX_P_DATA),
    .tx_vld    (TX_D_VLD),
    .done_c    (done_c)
  );

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign FRAME_ERR = err_q;

endmodule
